data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the datapath's data-memory port.
- Serves one outstanding load/store at a time over a valid/ready request channel and a valid/ready response channel.
- Inserts a programmable number of wait states, so the core can be moved from the single-cycle data memory to a stallable memory model.
- Holds a word-organised RAM with byte-enable writes and flags misaligned or out-of-range accesses.

Parameters:
- DATA_W, 32, data word width (fixed at 32; byte enables assume 4 lanes).
- DEPTH, 32, number of words in the RAM.
- WAIT_CYCLES, 2, wait states between accepting a request and committing it; 0 is legal.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errored accesses.
- rsp_err  out  1  access misaligned or out of range.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; WAIT counter cleared.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch req_write, req_addr, req_wdata, req_be.
  - If WAIT_CYCLES>0: load counter with WAIT_CYCLES-1 and go to WAIT. Otherwise commit and go to RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When counter==0: commit and go to RESP.
- Commit (single edge, on entry to RESP):
  - Word index = addr[31:2].
  - err = (addr[1:0]!=0) or (index >= DEPTH).
  - If err: no RAM write; rsp_rdata=0; rsp_err=1.
  - Store, no error: write bytes selected by be into RAM[index]. be=0000 is a legal no-op. rsp_rdata=0.
  - Load, no error: rsp_rdata = RAM[index], all 4 bytes regardless of be.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stay stable until the handshake.
  - On rsp_ready=1: rsp_valid drops next cycle, rsp_rdata and rsp_err clear to 0, go to IDLE.
  - Without the optional feature, req_ready=0 in RESP.
- Latency:
  - Request accepted at edge N → rsp_valid high from cycle N+WAIT_CYCLES+1.
  - Minimum turnaround without the optional feature is WAIT_CYCLES+2 cycles per access.
- Boundary conditions:
  - Requests while busy: ignored. req_ready=0, nothing latched; the requester holds its request.
  - rsp_ready held high before rsp_valid: handshake completes in the first RESP cycle.
  - Address wrap: none. An index >= DEPTH is an error, never aliased.
  - Reset during WAIT: the pending store is discarded and RAM is unchanged.
  - Reset during RESP: the response is dropped; an already committed store remains in RAM.
  - Store followed by load to the same address: the load returns the new data, since commit precedes the next accept.

Optional Feature:
- Macro: DATA_MEM_RESP_FWD_EN.
- Defined: in RESP, req_ready = rsp_ready.
  - A request presented in the same cycle as the response handshake is accepted at that edge.
  - The FSM goes straight to WAIT, or to commit+RESP when WAIT_CYCLES=0.
  - Gives back-to-back throughput of one access per WAIT_CYCLES+1 cycles.
- Undefined: req_ready=0 in RESP; IDLE is always revisited between accesses.

Test Plan:
- Reset then store: WAIT_CYCLES=2, rst low mid-cycle.
  - Outputs go to reset values asynchronously, with no clock.
  - Then store addr=0x08, wdata=0xDEADBEEF, be=1111: rsp_valid rises 3 cycles after accept, rsp_err=0, rsp_rdata=0.
  - A following load from 0x08 returns 0xDEADBEEF.
- Byte enables: store 0x11223344 to 0x0C with be=0101 over a word holding 0xAABBCCDD → a load from 0x0C returns 0xAA22CC44.
- Errors:
  - Load at 0x0A → rsp_err=1, rsp_rdata=0.
  - Store at 0x80 (index 32, DEPTH=32) → rsp_err=1, RAM unchanged (verify by loading 0x00–0x7C).
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid, rsp_rdata and rsp_err stay stable; req_ready=0; a second request is not accepted.
  - Release rsp_ready → the second request is accepted in IDLE the cycle after.
- Reset in WAIT: assert rst in the middle of a store to 0x10 of 0x55AA55AA → a load from 0x10 returns the old value; FSM is in IDLE with busy=0.
- DATA_MEM_RESP_FWD_EN: WAIT_CYCLES=0, 4 back-to-back loads with rsp_ready tied high.
  - One response per 1 cycle (vs 2 cycles without the macro).
  - Data matches the preloaded words 0x0, 0x4, 0x8, 0xC.

Source files
------------

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the datapath data-memory port. Accepts one
// load/store at a time on a valid/ready request channel, waits WAIT_CYCLES
// wait states, commits the access against a word-organised RAM with byte
// enables, and returns the result on a valid/ready response channel.
// Misaligned addresses and word indices >= DEPTH are flagged with rsp_err and
// never touch the RAM.
//
// Optional feature (macro DATA_MEM_RESP_FWD_EN): in RESP, req_ready follows
// rsp_ready so a new request can be accepted on the response handshake edge.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   req_valid  request present
//   req_ready  responder can accept a request this cycle
//   req_write  1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data
//   req_be     byte enables, bit i covers bits [8i+7:8i]
//   rsp_valid  response present
//   rsp_ready  requester accepts the response
//   rsp_rdata  load data (0 for stores and errored accesses)
//   rsp_err    misaligned or out-of-range access
//   busy       FSM not in IDLE
//
// state  | meaning
// IDLE   | ready for a request
// WAIT   | request latched, counting down wait states
// RESP   | access committed, response presented until handshake
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD  = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
    localparam logic [29:0]   DEPTH_IDX = 30'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;

    logic              lat_write;
    logic [31:0]       lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [3:0]        lat_be;

    logic accept;
    logic commit;
    logic commit_direct;
    logic rsp_clear;

    logic              c_write;
    logic [31:0]       c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [3:0]        c_be;
    logic [29:0]       c_idx;
    logic              c_err;

    logic [DATA_W-1:0] mem [DEPTH];

    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        req_ready     = 1'b0;
        accept        = 1'b0;
        commit        = 1'b0;
        commit_direct = 1'b0;
        rsp_clear     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        commit        = 1'b1;
                        commit_direct = 1'b1;
                        state_d       = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    commit  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            S_RESP: begin
`ifdef DATA_MEM_RESP_FWD_EN
                req_ready = rsp_ready;
`endif
                if (rsp_ready) begin
                    rsp_clear = 1'b1;
                    state_d   = S_IDLE;
`ifdef DATA_MEM_RESP_FWD_EN
                    if (req_valid) begin
                        accept = 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state_d = S_WAIT;
                            cnt_d   = CNT_LOAD;
                        end else begin
                            commit        = 1'b1;
                            commit_direct = 1'b1;
                            state_d       = S_RESP;
                        end
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the access commits on the accept edge, so it
    // must be taken straight from the request bus rather than the latch.
    assign c_write = commit_direct ? req_write : lat_write;
    assign c_addr  = commit_direct ? req_addr  : lat_addr;
    assign c_wdata = commit_direct ? req_wdata : lat_wdata;
    assign c_be    = commit_direct ? req_be    : lat_be;
    assign c_idx   = c_addr[31:2];
    assign c_err   = (c_addr[1:0] != 2'b00) || (c_idx >= DEPTH_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end
            // A forwarded commit on the handshake edge replaces the clear.
            if (commit) begin
                rsp_err   <= c_err;
                rsp_rdata <= (c_err || c_write) ? '0 : mem[c_idx[AW-1:0]];
            end else if (rsp_clear) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

    // RAM is not reset; rst gates the write so an IDLE-state request seen
    // while reset is held cannot commit.
    always_ff @(posedge clk) begin
        if (rst && commit && c_write && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) begin
                    mem[c_idx[AW-1:0]][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench for data_mem_responder. Main instance uses WAIT_CYCLES=2;
// a second instance with WAIT_CYCLES=0 is streamed back-to-back to measure
// response spacing (1 cycle with DATA_MEM_RESP_FWD_EN, 2 without).
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_write;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [3:0]  b_req_be;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
    logic [31:0] b_rsp_rdata;

    int tests = 0;
    int fails = 0;

    logic [31:0] model [32];
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    logic [31:0] pat      [4];
    int          resp_cyc [8];
    logic [31:0] resp_dat [8];
    int          nr, k, cyc;
    logic        acc;

`ifdef DATA_MEM_RESP_FWD_EN
    localparam int SPACING = 1;
`else
    localparam int SPACING = 2;
`endif

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_W(32), .DEPTH(32), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    data_mem_responder #(.DATA_W(32), .DEPTH(32), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns just after the accept edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        int m = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        while (!req_ready && m < 20) begin
            tick();
            m++;
        end
        check("accept_bound", 32'(m < 20), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // lat counts cycles from the accept cycle: the cycle right after the
    // accept edge is 1, so WAIT_CYCLES=2 gives rsp_valid at lat=3.
    task automatic finish_rsp(output logic [31:0] rdo, output logic ero, output int lato);
        lato = 1;
        while (!rsp_valid && lato < 20) begin
            tick();
            lato++;
        end
        check("rsp_bound", 32'(rsp_valid), 32'd1);
        rdo = rsp_rdata;
        ero = rsp_err;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("hs_clear", {28'd0, rsp_valid, busy, rsp_err, |rsp_rdata}, 32'd0);
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] rdo, output logic ero,
                          output int lato);
        issue(w, a, d, be);
        finish_rsp(rdo, ero, lato);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        b_req_be = '0; b_rsp_ready = 1'b0;

        // Asynchronous reset asserted mid-cycle, checked before any edge.
        tick();
        tick();
        #3 rst = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err",   32'(rsp_err), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        access(1'b1, 32'h08, 32'hDEADBEEF, 4'b1111, rd, er, lat);
        check("st08_latency", 32'(lat), 32'd3);
        check("st08_err",     32'(er), 32'd0);
        check("st08_rdata",   rd, 32'd0);
        model[2] = 32'hDEADBEEF;

        access(1'b0, 32'h08, 32'h0, 4'b0000, rd, er, lat);
        check("ld08_rdata",   rd, 32'hDEADBEEF);
        check("ld08_err",     32'(er), 32'd0);
        check("ld08_latency", 32'(lat), 32'd3);

        for (int i = 0; i < 32; i++) begin
            if (i != 2) begin
                model[i] = {8'(i), 8'hA5, 8'(i + 1), 8'h5A};
                access(1'b1, 32'(i * 4), model[i], 4'b1111, rd, er, lat);
            end
        end

        access(1'b1, 32'h0C, 32'hAABBCCDD, 4'b1111, rd, er, lat);
        access(1'b1, 32'h0C, 32'h11223344, 4'b0101, rd, er, lat);
        access(1'b0, 32'h0C, 32'h0, 4'b1111, rd, er, lat);
        check("be_merge", rd, 32'hAA22CC44);
        model[3] = 32'hAA22CC44;

        access(1'b0, 32'h0A, 32'h0, 4'b1111, rd, er, lat);
        check("misalign_err",   32'(er), 32'd1);
        check("misalign_rdata", rd, 32'd0);

        access(1'b1, 32'h80, 32'hFFFFFFFF, 4'b1111, rd, er, lat);
        check("oor_err",   32'(er), 32'd1);
        check("oor_rdata", rd, 32'd0);
        for (int i = 0; i < 32; i++) begin
            access(1'b0, 32'(i * 4), 32'h0, 4'b1111, rd, er, lat);
            check($sformatf("ram_scan_%0d", i), rd, model[i]);
        end

        // Backpressure: response held for 5 cycles while a second request waits.
        issue(1'b0, 32'h08, 32'h0, 4'b1111);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0C;
        req_be    = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_hold_flags", {28'd0, rsp_valid, req_ready, busy, rsp_err}, 32'b1010);
            check("bp_hold_rdata", rsp_rdata, 32'hDEADBEEF);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`ifdef DATA_MEM_RESP_FWD_EN
        req_valid = 1'b0;
        check("bp_fwd_accept", {30'd0, busy, rsp_valid}, 32'b10);
`else
        check("bp_idle_flags", {30'd0, req_ready, rsp_valid}, 32'b10);
        tick();
        req_valid = 1'b0;
        check("bp_second_acc", {30'd0, busy, req_ready}, 32'b10);
`endif
        finish_rsp(rd, er, lat);
        check("bp_second_data", rd, 32'hAA22CC44);
        check("bp_second_lat",  32'(lat), 32'd3);

        // rsp_ready high before rsp_valid: handshake in the first RESP cycle.
        rsp_ready = 1'b1;
        issue(1'b0, 32'h00, 32'h0, 4'b1111);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check("early_rdy_data", rsp_rdata, model[0]);
        tick();
        check("early_rdy_done", {30'd0, rsp_valid, busy}, 32'd0);
        rsp_ready = 1'b0;

        // Reset in WAIT discards the pending store.
        issue(1'b1, 32'h10, 32'h55AA55AA, 4'b1111);
        #2 rst = 1'b0;
        #1;
        check("rst_wait_flags", {29'd0, busy, req_ready, rsp_valid}, 32'b010);
        tick();
        rst = 1'b1;
        tick();
        access(1'b0, 32'h10, 32'h0, 4'b1111, rd, er, lat);
        check("rst_wait_ram", rd, model[4]);

        // Reset in RESP drops the response but keeps the committed store.
        issue(1'b1, 32'h18, 32'hCAFEF00D, 4'b1111);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        #2 rst = 1'b0;
        #1;
        check("rst_resp_flags", {30'd0, rsp_valid, busy}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        model[6] = 32'hCAFEF00D;
        access(1'b0, 32'h18, 32'h0, 4'b1111, rd, er, lat);
        check("rst_resp_ram", rd, model[6]);

        // WAIT_CYCLES=0 stream: 4 stores then 4 loads, rsp_ready tied high.
        pat[0] = 32'h0BAD0001;
        pat[1] = 32'h1234ABCD;
        pat[2] = 32'hF00DFACE;
        pat[3] = 32'h87654321;
        b_rsp_ready = 1'b1;
        nr  = 0;
        k   = 0;
        cyc = 0;
        while (nr < 8 && cyc < 60) begin
            b_req_valid = (k < 8);
            b_req_write = (k < 4);
            b_req_addr  = 32'((k % 4) * 4);
            b_req_wdata = pat[k % 4];
            b_req_be    = 4'b1111;
            #1;
            acc = b_req_valid && b_req_ready;
            if (b_rsp_valid) begin
                resp_cyc[nr] = cyc;
                resp_dat[nr] = b_rsp_rdata;
                nr++;
            end
            tick();
            cyc++;
            if (acc) k++;
        end
        b_req_valid = 1'b0;
        check("stream_count", 32'(nr), 32'd8);
        if (nr == 8) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("stream_st_%0d", i), resp_dat[i], 32'd0);
                check($sformatf("stream_ld_%0d", i), resp_dat[i + 4], pat[i]);
            end
            for (int i = 1; i < 8; i++) begin
                check($sformatf("stream_gap_%0d", i), 32'(resp_cyc[i] - resp_cyc[i - 1]),
                      32'(SPACING));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
